// File: rtl/csi2rx_dpcm_decoder_pkg.sv
// Shared constants, code classes and helpers for the CSI-2 10-8-10 DPCM decoder.
// Holds the prefix constants, reconstruction offsets and the pixel clamp limit.
package csi2rx_dpcm_decoder_pkg;

  localparam logic [1:0]         PFX_DPCM1  = 2'b00;
  localparam logic [2:0]         PFX_DPCM2  = 3'b010;
  localparam logic [2:0]         PFX_DPCM3  = 3'b011;
  localparam logic               PFX_PCM    = 1'b1;
  localparam logic signed [11:0] NOPRED_OFS = 12'sd2;
  localparam logic signed [11:0] PCM_OFS_GT = 12'sd3;
  localparam logic signed [11:0] PCM_OFS_LE = 12'sd4;
  localparam logic signed [11:0] PIX_MAX    = 12'sd1023;
  localparam logic [2:0]         POS_FIRST  = 3'd1;
  localparam logic [2:0]         POS_SAT    = 3'd5;
  localparam int                 SCHEME_P1_BIT = 3;

  typedef enum logic [1:0] {
    CODE_DPCM1 = 2'd0,
    CODE_DPCM2 = 2'd1,
    CODE_DPCM3 = 2'd2,
    CODE_PCM   = 2'd3
  } code_class_e;

  function automatic code_class_e classify(input logic [7:0] code);
    code_class_e c;
    if (code[7] == PFX_PCM) begin
      c = CODE_PCM;
    end else if (code[7:6] == PFX_DPCM1) begin
      c = CODE_DPCM1;
    end else if (code[7:5] == PFX_DPCM2) begin
      c = CODE_DPCM2;
    end else begin
      c = CODE_DPCM3;
    end
    return c;
  endfunction

  function automatic logic [9:0] clamp_pix(input logic signed [11:0] v);
    logic [9:0] r;
    if (v < 12'sd0) begin
      r = 10'd0;
    end else if (v > PIX_MAX) begin
      r = 10'd1023;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

  function automatic logic is_monotonic(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
    return ((a <= b) && (b <= c)) || ((a >= b) && (b >= c));
  endfunction

endpackage

// File: rtl/csi2rx_predictor.sv
// Decoded-pixel history (d1 newest .. d4 oldest) and position-based predictor
// selection for both CSI-2 predictors; pred is valid only when no_pred_o is low.
module csi2rx_predictor
  import csi2rx_dpcm_decoder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic [9:0] pix_i,
  input  logic [2:0] pos_i,
  input  logic       pred1_i,
  output logic [9:0] pred_o,
  output logic       no_pred_o
);

  logic [9:0]  d1_q, d2_q, d3_q, d4_q;
  logic [9:0]  d1_d, d2_d, d3_d, d4_d;
  logic [10:0] avg_sum;
  logic [9:0]  avg;

  // History next state; a same-cycle clear and shift leaves only the new pixel.
  always_comb begin
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    d4_d = d4_q;
    if (clear_i && shift_i) begin
      d1_d = pix_i;
      d2_d = 10'd0;
      d3_d = 10'd0;
      d4_d = 10'd0;
    end else if (clear_i) begin
      d1_d = 10'd0;
      d2_d = 10'd0;
      d3_d = 10'd0;
      d4_d = 10'd0;
    end else if (shift_i) begin
      d1_d = pix_i;
      d2_d = d1_q;
      d3_d = d2_q;
      d4_d = d3_q;
    end else begin
      d1_d = d1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1_q <= 10'd0;
      d2_q <= 10'd0;
      d3_q <= 10'd0;
      d4_q <= 10'd0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
      d4_q <= d4_d;
    end
  end

  // Prediction selection by predictor type and line position.
  always_comb begin
    avg_sum   = {1'b0, d2_q} + {1'b0, d4_q} + 11'd1;
    avg       = 10'(avg_sum >> 1);
    pred_o    = 10'd0;
    no_pred_o = 1'b0;
    if (pred1_i) begin
      if (pos_i <= 3'd2) begin
        no_pred_o = 1'b1;
      end else begin
        pred_o = d2_q;
      end
    end else begin
      case (pos_i)
        3'd1: no_pred_o = 1'b1;
        3'd2: pred_o = d1_q;
        3'd3: pred_o = d2_q;
        3'd4: pred_o = is_monotonic(d1_q, d2_q, d3_q) ? d1_q : d2_q;
        default: begin
          if (is_monotonic(d1_q, d2_q, d3_q)) begin
            pred_o = d1_q;
          end else if (((d1_q <= d3_q) && (d2_q <= d4_q)) ||
                       ((d1_q >= d3_q) && (d2_q >= d4_q))) begin
            pred_o = d2_q;
          end else begin
            pred_o = avg;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/csi2rx_dpcm_decoder.sv
// CSI-2 receive-side 10-8-10 DPCM decompressor: one 8-bit code in, one 10-bit
// pixel out per cycle, registered one cycle after the accepting code.
module csi2rx_dpcm_decoder
  import csi2rx_dpcm_decoder_pkg::*;
(
  input  logic       sensor_clk,
  input  logic       sys_rst_n,
  input  logic [4:0] comp_scheme,
  input  logic       line_start,
  input  logic       code_valid,
  input  logic [7:0] code_data,
  output logic       pix_valid,
  output logic [9:0] pix_data
);

  logic [4:0]         scheme_q, scheme_d, scheme_eff;
  logic [2:0]         pos_q, pos_d, pos_eff;
  logic               pix_valid_q, pix_valid_d;
  logic [9:0]         pix_data_q, pix_data_d;
  logic               bypass, accept_cmp;
  logic [9:0]         pred;
  logic               no_pred;
  logic signed [11:0] pred_s, pcm_t, raw;
  logic [11:0]        delta;
  logic               neg;
  logic [9:0]         dec_pix;
  code_class_e        cls;

  // A line_start takes effect for a code accepted in the same cycle.
  always_comb begin
    if (line_start) begin
      scheme_eff = comp_scheme;
      pos_eff    = POS_FIRST;
    end else begin
      scheme_eff = scheme_q;
      pos_eff    = pos_q;
    end
    bypass     = (scheme_eff == 5'd0);
    accept_cmp = code_valid && !bypass;
  end

  csi2rx_predictor u_predictor (
    .clk_i     (sensor_clk),
    .rst_ni    (sys_rst_n),
    .clear_i   (line_start),
    .shift_i   (accept_cmp),
    .pix_i     (dec_pix),
    .pos_i     (pos_eff),
    .pred1_i   (scheme_eff[SCHEME_P1_BIT]),
    .pred_o    (pred),
    .no_pred_o (no_pred)
  );

  // Code decode and reconstruction against the prediction.
  always_comb begin
    cls    = classify(code_data);
    pred_s = signed'({2'b00, pred});
    pcm_t  = signed'({2'b00, code_data[6:0], 3'b000});
    neg    = (cls == CODE_DPCM1) ? code_data[5] : code_data[4];
    case (cls)
      CODE_DPCM1: delta = {7'd0, code_data[4:0]};
      CODE_DPCM2: delta = {7'd0, code_data[3:0], 1'b0} + 12'd32;
      CODE_DPCM3: delta = {6'd0, code_data[3:0], 2'b00} + 12'd65;
      default:    delta = 12'd0;
    endcase
    if (no_pred) begin
      raw = signed'({2'b00, code_data, 2'b00}) + NOPRED_OFS;
    end else if (cls == CODE_PCM) begin
      raw = pcm_t + ((pcm_t > pred_s) ? PCM_OFS_GT : PCM_OFS_LE);
    end else if (neg) begin
      raw = pred_s - signed'(delta);
    end else begin
      raw = pred_s + signed'(delta);
    end
    dec_pix = clamp_pix(raw);
  end

  // Next state for scheme, position and output registers.
  always_comb begin
    scheme_d    = scheme_q;
    pos_d       = pos_q;
    pix_valid_d = code_valid;
    pix_data_d  = pix_data_q;
    if (line_start) begin
      scheme_d = comp_scheme;
    end else begin
      scheme_d = scheme_q;
    end
    if (accept_cmp) begin
      pos_d = (pos_eff >= POS_SAT) ? POS_SAT : pos_eff + 3'd1;
    end else if (line_start) begin
      pos_d = POS_FIRST;
    end else begin
      pos_d = pos_q;
    end
    if (code_valid) begin
      pix_data_d = bypass ? {code_data, 2'b00} : dec_pix;
    end else begin
      pix_data_d = pix_data_q;
    end
  end

  always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scheme_q    <= 5'd0;
      pos_q       <= POS_FIRST;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 10'd0;
    end else begin
      scheme_q    <= scheme_d;
      pos_q       <= pos_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_csi2rx_dpcm_decoder.sv
// Self-checking bench for csi2rx_dpcm_decoder: directed vector table, reset
// corner case, then random codes against an integer reference model.
module tb_csi2rx_dpcm_decoder;

  logic       sensor_clk = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic [4:0] comp_scheme = 5'd0;
  logic       line_start = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code_data  = 8'd0;
  logic       pix_valid;
  logic [9:0] pix_data;

  always #5 sensor_clk = ~sensor_clk;

  csi2rx_dpcm_decoder dut (
    .sensor_clk  (sensor_clk),
    .sys_rst_n   (sys_rst_n),
    .comp_scheme (comp_scheme),
    .line_start  (line_start),
    .code_valid  (code_valid),
    .code_data   (code_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data)
  );

  localparam logic [4:0] SCH_BYP = 5'd0;
  localparam logic [4:0] SCH_P1  = 5'b01000;
  localparam logic [4:0] SCH_P2  = 5'b00001;

  typedef struct {
    bit         ls;
    bit         v;
    logic [7:0] code;
    logic [4:0] sch;
    bit         exp_v;
    int         exp_pix;
  } vec_t;

  int total  = 0;
  int passed = 0;

  // Reference model state: scheme, pixel count in line, last four pixels.
  int mscheme = 0;
  int mcount  = 0;
  int mhist[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int hist(input int k);
    return (mhist.size() >= k) ? mhist[mhist.size() - k] : 0;
  endfunction

  function automatic bit mono(input int a, input int b, input int c);
    return (a <= b && b <= c) || (a >= b && b >= c);
  endfunction

  // Returns -1 when the position has no prediction.
  function automatic int ref_pred(input int n, input bit p1);
    int d1, d2, d3, d4;
    d1 = hist(1); d2 = hist(2); d3 = hist(3); d4 = hist(4);
    if (p1) return (n <= 2) ? -1 : d2;
    if (n == 1) return -1;
    if (n == 2) return d1;
    if (n == 3) return d2;
    if (n == 4) return mono(d1, d2, d3) ? d1 : d2;
    if (mono(d1, d2, d3)) return d1;
    if ((d1 <= d3 && d2 <= d4) || (d1 >= d3 && d2 >= d4)) return d2;
    return (d2 + d4 + 1) / 2;
  endfunction

  function automatic int ref_decode(input int code, input int pred);
    int t, mag, s, r;
    if (pred < 0) return code * 4 + 2;
    if (code >= 128) begin
      t = (code % 128) * 8;
      return (t > pred) ? t + 3 : t + 4;
    end
    if (code < 64) begin
      mag = code % 32;          s = (code / 32) % 2;
    end else if (code < 96) begin
      mag = 2 * (code % 16) + 32; s = (code / 16) % 2;
    end else begin
      mag = 4 * (code % 16) + 65; s = (code / 16) % 2;
    end
    r = s ? pred - mag : pred + mag;
    if (r < 0) r = 0;
    if (r > 1023) r = 1023;
    return r;
  endfunction

  task automatic model_reset();
    mscheme = 0; mcount = 0; mhist.delete();
  endtask

  task automatic model_step(input bit ls, input bit v, input int code, input int sch,
                            output int ed);
    int n, p;
    if (ls) begin
      mscheme = sch; mcount = 0; mhist.delete();
    end
    ed = -1;
    if (v) begin
      if (mscheme == 0) begin
        ed = code * 4;
      end else begin
        n  = mcount + 1;
        p  = ref_pred(n, ((mscheme / 8) % 2) == 1);
        ed = ref_decode(code, p);
        mcount++;
        mhist.push_back(ed);
        if (mhist.size() > 4) void'(mhist.pop_front());
      end
    end
  endtask

  task automatic cyc(input bit ls, input bit v, input logic [7:0] code, input logic [4:0] sch);
    @(negedge sensor_clk);
    line_start = ls; code_valid = v; code_data = code; comp_scheme = sch;
    @(posedge sensor_clk);
    #1;
  endtask

  task automatic step_and_check(input string tag, input bit ls, input bit v,
                                input logic [7:0] code, input logic [4:0] sch);
    int ed;
    cyc(ls, v, code, sch);
    model_step(ls, v, int'(code), int'(sch), ed);
    check({tag, " valid"}, int'(pix_valid), int'(v));
    if (v) check({tag, " pix"}, int'(pix_data), ed);
  endtask

  vec_t vec[$];

  initial begin
    int ed;
    vec = '{
      '{1, 1, 8'h40, SCH_P2, 1, 258},  '{0, 1, 8'h05, SCH_P2, 1, 263},
      '{0, 1, 8'h25, SCH_P2, 1, 253},  '{1, 1, 8'h40, SCH_P2, 1, 258},
      '{0, 1, 8'h53, SCH_P2, 1, 220},  '{0, 1, 8'h90, SCH_P2, 1, 132},
      '{1, 1, 8'hFF, SCH_P2, 1, 1022}, '{0, 1, 8'h1F, SCH_P2, 1, 1023},
      '{1, 1, 8'h00, SCH_P2, 1, 2},    '{0, 1, 8'h3F, SCH_P2, 1, 0},
      '{1, 1, 8'h10, SCH_P1, 1, 66},   '{0, 1, 8'h20, SCH_P1, 1, 130},
      '{0, 1, 8'h03, SCH_P1, 1, 69},   '{1, 1, 8'hA5, SCH_BYP, 1, 'h294},
      '{0, 1, 8'h05, SCH_P2, 1, 20},   '{1, 1, 8'h40, SCH_P2, 1, 258},
      '{0, 1, 8'h05, SCH_P2, 1, 263},  '{0, 0, 8'h77, SCH_P2, 0, 0},
      '{0, 0, 8'h11, SCH_P2, 0, 0},    '{0, 0, 8'hEE, SCH_P2, 0, 0},
      '{0, 1, 8'h25, SCH_P2, 1, 253},  '{1, 0, 8'h00, SCH_P2, 0, 0},
      '{0, 1, 8'h10, SCH_P2, 1, 66}
    };

    repeat (3) @(negedge sensor_clk);
    check("reset valid", int'(pix_valid), 0);
    check("reset pix", int'(pix_data), 0);
    sys_rst_n = 1'b1;
    model_reset();

    foreach (vec[i]) begin
      cyc(vec[i].ls, vec[i].v, vec[i].code, vec[i].sch);
      model_step(vec[i].ls, vec[i].v, int'(vec[i].code), int'(vec[i].sch), ed);
      check($sformatf("vec%0d valid", i), int'(pix_valid), int'(vec[i].exp_v));
      if (vec[i].exp_v) check($sformatf("vec%0d pix", i), int'(pix_data), vec[i].exp_pix);
    end

    // Reset mid-line: outputs clear at once, rest of line decodes in bypass.
    cyc(1, 1, 8'h40, SCH_P2);
    check("pre-rst pix1", int'(pix_data), 258);
    cyc(0, 1, 8'h05, SCH_P2);
    check("pre-rst pix2", int'(pix_data), 263);
    @(negedge sensor_clk);
    code_valid = 1'b0; line_start = 1'b0; sys_rst_n = 1'b0;
    #1;
    check("midrst valid", int'(pix_valid), 0);
    check("midrst pix", int'(pix_data), 0);
    @(negedge sensor_clk);
    sys_rst_n = 1'b1;
    model_reset();
    cyc(0, 1, 8'h25, SCH_P2);
    check("post-rst bypass", int'(pix_data), 148);
    cyc(1, 1, 8'h40, SCH_P2);
    check("post-rst line", int'(pix_data), 258);
    model_step(1, 1, 'h40, int'(SCH_P2), ed);

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] sch;
      bit ls, v;
      case ($urandom_range(0, 3))
        0: sch = SCH_BYP;
        1: sch = SCH_P1;
        2: sch = SCH_P2;
        default: sch = 5'($urandom_range(0, 31));
      endcase
      ls = (i == 0) || ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 4) != 0);
      step_and_check($sformatf("rnd%0d", i), ls, v, 8'($urandom_range(0, 255)), sch);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
